// File: rtl/store_size_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : store_size_ctrl
// Purpose  : SW/SH/SB store engine; sub-word stores use read-modify-write.
// Option   : STORE_ALIGN_CHECK_EN rejects misaligned half/word requests.
// Revision : 1.0 - initial release
// ============================================================================
module store_size_ctrl #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata_in,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [2:0] c_lat_last = 3'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [2:0]  r_lat_cnt;
  logic        w_is_word;
  logic        w_bad_align;
  logic        w_accept;
  logic [31:0] w_merged;

  assign w_is_word = (size == 2'b00) || (size == 2'b11);
  assign w_accept  = (r_state == S_IDLE) && start;

`ifdef STORE_ALIGN_CHECK_EN
  assign w_bad_align = ((size == 2'b01) && addr[0]) ||
                       (w_is_word && (addr[1:0] != 2'b00));
`else
  assign w_bad_align = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    mem_wr   = 1'b0;
    done     = 1'b0;
    misalign = 1'b0;
    busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad_align)    w_next = S_ERR;
          else if (w_is_word) w_next = S_WR;
          else                w_next = S_RD;
        end
      end
      S_RD:    if (r_lat_cnt == c_lat_last) w_next = S_MERGE;
      S_MERGE: w_next = S_WR;
      S_WR: begin
        mem_wr = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
`ifdef STORE_ALIGN_CHECK_EN
        misalign = 1'b1;
`endif
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Half stores pick the lane from addr[1] only; addr[0] never matters here.
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == 2'b01) begin
      if (r_lane[1]) w_merged[31:16] = r_wdata;
      else           w_merged[15:0]  = r_wdata;
    end else begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_size    <= 2'b00;
      r_lane    <= 2'b00;
      r_wdata   <= 16'h0000;
      r_lat_cnt <= 3'd0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_size    <= size;
        r_lane    <= addr[1:0];
        r_wdata   <= wdata_in[15:0];
        r_lat_cnt <= 3'd0;
        // A rejected request leaves the memory-side outputs untouched.
        if (!w_bad_align) begin
          mem_addr <= {addr[ADDR_W-1:2], 2'b00};
          if (w_is_word) mem_wdata <= wdata_in;
        end
      end
      if (r_state == S_RD)    r_lat_cnt <= r_lat_cnt + 3'd1;
      if (r_state == S_MERGE) mem_wdata <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_size_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_size_ctrl
// Purpose  : scoreboard bench for store_size_ctrl with a word-memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_size_ctrl;

  localparam int MEM_LAT = 1;
  localparam int ADDR_W  = 32;

  logic              clk      = 1'b0;
  logic              reset    = 1'b0;
  logic              start    = 1'b0;
  logic [1:0]        size     = 2'b00;
  logic [ADDR_W-1:0] addr     = '0;
  logic [31:0]       wdata_in = 32'h0;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              misalign;

  always #5 clk = ~clk;

  store_size_ctrl #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata_in  (wdata_in),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks   = 0;
  int          n_fail     = 0;
  int          n_done     = 0;
  int          n_done_exp = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] dut_mem [16];
  logic [31:0] rpipe   [MEM_LAT];
  logic        poke_en  = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'h0;

  // Memory seen by the DUT: data appears MEM_LAT cycles after the address.
  always @(posedge clk) begin
    if (poke_en)     dut_mem[poke_idx] <= poke_val;
    else if (mem_wr) dut_mem[mem_addr[5:2]] <= mem_wdata;
    rpipe[0] <= dut_mem[mem_addr[5:2]];
    for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[MEM_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_event(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred with no matching expectation", nm);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mem_wr === 1'b1) begin
        if (exp_q.size() == 0) fail_event("unexpected_write");
        else begin
          mon_e = exp_q.pop_front();
          chk("wr_is_err", 32'(mon_e.is_err), 32'h0);
          chk("wr_addr", mem_addr, mon_e.a);
          chk("wr_data", mem_wdata, mon_e.d);
        end
      end
      if (misalign === 1'b1) begin
        if (exp_q.size() == 0) fail_event("unexpected_misalign");
        else begin
          mon_e = exp_q.pop_front();
          chk("err_is_err", 32'(mon_e.is_err), 32'h1);
        end
      end
      if (done === 1'b1) n_done++;
    end
  end

  // Reference: what a store of this size does to a little-endian word.
  task automatic model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          w;
    int          sh;
    logic [31:0] mask;
    logic [31:0] nw;
    bit          bad;
    bad = 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
    if (sz == 2'b01 && (a % 4) % 2 == 1) bad = 1'b1;
    if ((sz == 2'b00 || sz == 2'b11) && (a % 4) != 0) bad = 1'b1;
`endif
    w = int'(a[5:2]);
    if (bad) begin
      e.is_err = 1'b1;
      e.a      = 32'h0;
      e.d      = 32'h0;
    end else begin
      if (sz == 2'b10) begin
        sh   = 8 * int'(a % 4);
        mask = 32'hFF << sh;
        nw   = (ref_mem[w] & ~mask) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'b01) begin
        sh   = ((a % 4) >= 2) ? 16 : 0;
        mask = 32'hFFFF << sh;
        nw   = (ref_mem[w] & ~mask) | ((wd & 32'hFFFF) << sh);
      end else begin
        nw = wd;
      end
      ref_mem[w] = nw;
      e.is_err   = 1'b0;
      e.a        = a & ~32'h3;
      e.d        = nw;
      n_done_exp++;
    end
    exp_q.push_back(e);
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] v);
    poke_idx = idx;
    poke_val = v;
    poke_en  = 1'b1;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int g;
    g = 0;
    while (busy !== 1'b0) begin
      if (g > 50) begin
        fail_event(nm);
        return;
      end
      g++;
      @(negedge clk);
    end
  endtask

  // Returns just after the edge that samples start (the "edge 0").
  task automatic issue(input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_model);
    wait_idle("issue_timeout");
    size     = sz;
    addr     = a;
    wdata_in = wd;
    start    = 1'b1;
    if (use_model) model(sz, a, wd);
    @(posedge clk);
    #1;
    start    = 1'b0;
    size     = 2'($urandom_range(0, 3));
    addr     = $urandom;
    wdata_in = $urandom;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    for (int i = 0; i < 16; i++) poke(4'(i), $urandom);
    @(negedge clk);
    reset = 1'b1;

    // Word store: written directly, done the cycle after
    issue(2'b00, 32'h10, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("sw_c1_mem_wr", 32'(mem_wr), 32'h1);
    chk("sw_c1_mem_addr", mem_addr, 32'h10);
    chk("sw_c1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_c2_done", 32'(done), 32'h1);
    chk("sw_c2_mem_wr", 32'(mem_wr), 32'h0);

    // Byte store through read-modify-write
    @(negedge clk);
    poke(4'd8, 32'h11223344);
    issue(2'b10, 32'h22, 32'h000000AB, 1'b1);
    for (int c = 1; c <= MEM_LAT + 1; c++) begin
      @(negedge clk);
      chk("sb_early_mem_wr", 32'(mem_wr), 32'h0);
      chk("sb_early_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk("sb_wr_mem_wr", 32'(mem_wr), 32'h1);
    chk("sb_wr_mem_addr", mem_addr, 32'h20);
    chk("sb_wr_mem_wdata", mem_wdata, 32'h11AB3344);
    @(negedge clk);
    chk("sb_done", 32'(done), 32'h1);

    // Half stores into both lanes
    @(negedge clk);
    poke(4'd1, 32'h11223344);
    issue(2'b01, 32'h6, 32'hFFFFCAFE, 1'b1);
    wait_idle("sh_hi_timeout");
    @(negedge clk);
    chk("sh_hi_mem", dut_mem[1], 32'hCAFE3344);
    poke(4'd1, 32'h11223344);
    issue(2'b01, 32'h4, 32'hFFFFCAFE, 1'b1);
    wait_idle("sh_lo_timeout");
    @(negedge clk);
    chk("sh_lo_mem", dut_mem[1], 32'h1122CAFE);

    // start held high through RD and MERGE must be ignored
    issue(2'b10, 32'h09, 32'h0000005A, 1'b1);
    @(negedge clk);
    start = 1'b1;
    size  = 2'b00;
    addr  = 32'h30;
    repeat (MEM_LAT + 1) @(negedge clk);
    start = 1'b0;
    wait_idle("ignore_timeout");

    // Reset in the middle of a byte store aborts it
    @(negedge clk);
    issue(2'b10, 32'h0C, 32'h00000077, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_word3_intact", dut_mem[3], ref_mem[3]);
    issue(2'b00, 32'h14, 32'h0BADF00D, 1'b1);
    wait_idle("post_abort_timeout");

    // Half store with addr[0] set
    @(negedge clk);
    issue(2'b01, 32'h3, 32'h1234BEEF, 1'b1);
`ifdef STORE_ALIGN_CHECK_EN
    @(negedge clk);
    chk("mis_c1_misalign", 32'(misalign), 32'h1);
    chk("mis_c1_mem_wr", 32'(mem_wr), 32'h0);
    @(negedge clk);
    chk("mis_c2_busy", 32'(busy), 32'h0);
`endif
    wait_idle("mis_timeout");

    // Randomized stores, including reserved size and all offsets
    for (int n = 0; n < 80; n++) begin
      issue(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    wait_idle("final_timeout");
    repeat (5) @(negedge clk);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("done_count", 32'(n_done), 32'(n_done_exp));
    for (int i = 0; i < 16; i++) chk("final_mem", dut_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_size_ctrl.md
Name: store_size_ctrl

Overview:
- Write-side counterpart of the load-size path. Takes a register operand and a byte address and performs SW/SH/SB stores into the 32-bit word memory.
- Word stores are written directly.
- Byte and half stores use a read-modify-write sequence: fetch the containing word, merge the slice, write back.
- Sits between the register file B operand / address register and the memory port. The control unit starts it and waits for `done`.

Parameters:
- MEM_LAT, 1: cycles from memory address presentation until `mem_rdata` is valid (1..4).
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- size  in  2  00=word (SW), 01=half (SH), 10=byte (SB), 11=reserved, treated as word.
- addr  in  ADDR_W  target byte address.
- wdata_in  in  32  register value to store; the low byte or half is used for SB/SH.
- mem_rdata  in  32  memory read data.
- mem_addr  out  ADDR_W  word-aligned memory address {addr[ADDR_W-1:2],2'b00}.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  merged word to write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the store has completed.
- misalign  out  1  one-cycle pulse when a misaligned request is rejected.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; mem_addr=0, mem_wr=0, mem_wdata=0, busy=0, done=0, misalign=0.
  - Internal buffers cleared.
  - Reset during any state aborts the operation. mem_wr drops immediately; no partial write occurs.
- Input capture: on the edge where start=1 in IDLE, the block latches addr, size and wdata_in. Later input changes have no effect.
- start is ignored while busy=1; no queueing.
- States: IDLE, RD, MERGE, WR, DONE, ERR.
- Transitions:
  - IDLE -> WR: word store.
  - IDLE -> RD: half/byte store.
  - IDLE -> ERR: misaligned request.
  - RD holds for MEM_LAT cycles with mem_addr driven and mem_wr=0, then -> MERGE.
  - MERGE: captures mem_rdata, replaces the selected slice, stores the result in mem_wdata -> WR.
  - WR: mem_wr=1 for exactly one cycle, mem_addr stable -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: misalign=1 for one cycle, no memory access -> IDLE.
- Lane mapping (little-endian, k = latched addr[1:0]):
  - byte: bits [8k+7:8k] <- wdata_in[7:0].
  - half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16] <- wdata_in[15:0].
  - All other bits keep the fetched value.
- Word store: mem_wdata = wdata_in, no read.
- Latency, with start sampled at edge 0:
  - word: WR in cycle 1, done in cycle 2.
  - half/byte: RD in cycles 1..MEM_LAT, MERGE at MEM_LAT+1, WR at MEM_LAT+2, done at MEM_LAT+3.
- Outputs between operations:
  - mem_addr and mem_wdata hold their last values in IDLE.
  - mem_wr is 0 outside WR.
- Next operation: a new start is accepted in the cycle after DONE or ERR, when busy is already 0.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined:
  - half with addr[0]=1 -> ERR.
  - word or reserved with addr[1:0]!=0 -> ERR.
  - No memory access on ERR.
- Undefined:
  - ERR is unreachable and misalign is tied to 0.
  - half ignores addr[0].
  - word ignores addr[1:0].
  - The store proceeds to the aligned lane/word.

Test Plan:
- SW, addr=0x00000010, wdata_in=0xDEADBEEF, then start -> cycle 1: mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2: done=1; mem_rdata never consumed.
- SB, addr=0x00000022, wdata_in=0x000000AB, mem_rdata=0x11223344, MEM_LAT=1 -> WR at cycle 3 with mem_addr=0x20, mem_wdata=0x11AB3344; done at cycle 4.
- SH, addr=0x00000006, wdata_in=0xFFFFCAFE, mem_rdata=0x11223344 -> mem_wdata=0xCAFE3344; SH at addr 0x4 with same data -> 0x1122CAFE.
- Start pulsed again during RD and MERGE -> ignored; exactly one mem_wr pulse and one done pulse.
- reset driven low during RD of an SB, then released -> mem_wr never asserts; all outputs 0; next SW completes normally.
- With STORE_ALIGN_CHECK_EN, SH addr=0x00000003 -> misalign=1 at cycle 1, mem_wr stays 0, busy=0 at cycle 2.
- Without STORE_ALIGN_CHECK_EN, same request -> writes lane [31:16].
